// File: rtl/hash_sequencer.sv
// hash_sequencer: sequences a three-pass double-hash nonce search (INIT, LOAD, ROUND x ROUNDS, UPDATE, CHECK).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, stop, hit           begin search, finish after current nonce, comparator result
//   nonce_init                 first nonce, captured when start is accepted
//   block, load_msg, msg_sel   H-register control code, schedule load pulse, pass index
//   round_en, round_t          compression round strobe and index
//   nonce                      nonce under test
//   busy, done, found, exhausted  status; done pulses in the deciding CHECK cycle
module hash_sequencer #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        hit,
    input  logic [31:0] nonce_init,
    output logic [1:0]  block,
    output logic        load_msg,
    output logic [1:0]  msg_sel,
    output logic        round_en,
    output logic [5:0]  round_t,
    output logic [31:0] nonce,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        exhausted
);
    typedef enum logic [2:0] {IDLE, INIT, LOAD, ROUND, UPDATE, CHECK} state_t;
    state_t state, state_n;
    logic [1:0] pass, blk;
    logic stop_l, found_r, exh_r;
    logic last_round, stop_any, is_max, win, exh_now, finish;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb begin
        last_round = round_t == 6'(ROUNDS - 1);
        // a stop arriving in the CHECK cycle itself is honoured, not carried into the next nonce
        stop_any   = stop_l | stop;
        is_max     = &nonce;
        win        = state == CHECK && hit;
        exh_now    = state == CHECK && !hit && !stop_any && is_max;
        finish     = hit || stop_any || is_max;
        state_n    = state;
        case (state)
            IDLE:    state_n = start ? INIT : IDLE;
            INIT:    state_n = LOAD;
            LOAD:    state_n = ROUND;
            ROUND:   state_n = last_round ? UPDATE : ROUND;
            UPDATE:  state_n = pass == 2'd2 ? CHECK : LOAD;
            CHECK:   state_n = finish ? IDLE : INIT;
            default: state_n = IDLE;
        endcase
        busy      = state != IDLE;
        load_msg  = state == LOAD;
        round_en  = state == ROUND;
        done      = state == CHECK && finish;
        found     = found_r | win;
        exhausted = exh_r | exh_now;
        msg_sel   = pass;
        block     = blk;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            blk     <= 2'd0;
            pass    <= 2'd0;
            round_t <= 6'd0;
            nonce   <= 32'd0;
            stop_l  <= 1'b0;
            found_r <= 1'b0;
            exh_r   <= 1'b0;
        end else begin
            // block changes only on entry to INIT or UPDATE so each H register accumulates once per code
            blk     <= state_n == INIT ? 2'd0 : state_n == UPDATE ? pass + 2'd1 : blk;
            pass    <= state == INIT ? 2'd0 : (state == UPDATE && pass != 2'd2) ? pass + 2'd1 : pass;
            round_t <= (state == ROUND && !last_round) ? round_t + 6'd1 : 6'd0;
            nonce   <= (state == IDLE && start) ? nonce_init : (state == CHECK && !finish) ? nonce + 32'd1 : nonce;
            stop_l  <= (state == IDLE || state == CHECK) ? 1'b0 : stop_l | stop;
            found_r <= (state == IDLE && start) ? 1'b0 : found_r | win;
            exh_r   <= (state == IDLE && start) ? 1'b0 : exh_r | exh_now;
        end
endmodule

// File: tb/tb_hash_sequencer.sv
// tb_hash_sequencer: directed self-checking bench for hash_sequencer with ROUNDS=64.
module tb_hash_sequencer;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, hit = 1'b0;
    logic [31:0] nonce_init = 32'd0;
    logic [1:0] block, msg_sel;
    logic load_msg, round_en, busy, done, found, exhausted;
    logic [5:0] round_t;
    logic [31:0] nonce;
    int total = 0, passed = 0;
    hash_sequencer #(.ROUNDS(64)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .hit(hit),
        .nonce_init(nonce_init), .block(block), .load_msg(load_msg), .msg_sel(msg_sel),
        .round_en(round_en), .round_t(round_t), .nonce(nonce), .busy(busy),
        .done(done), .found(found), .exhausted(exhausted)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // {block, load_msg, round_en, round_t, done, busy} expected c cycles after start, first nonce, no finish
    function automatic logic [11:0] exp_trace(input int c);
        logic [1:0] b;
        logic ld, re;
        logic [5:0] rt;
        b  = c < 67 ? 2'd0 : c < 133 ? 2'd1 : c < 199 ? 2'd2 : 2'd3;
        ld = c == 2 || c == 68 || c == 134;
        re = (c >= 3 && c <= 66) || (c >= 69 && c <= 132) || (c >= 135 && c <= 198);
        rt = re ? 6'((c - 3) % 66) : 6'd0;
        return {b, ld, re, rt, 1'b0, 1'b1};
    endfunction
    initial begin
        cyc(2);
        check("rst_busy", busy, 0);
        check("rst_outs", {block, msg_sel, load_msg, round_en, round_t, done, found, exhausted}, 0);
        check("rst_nonce", nonce, 0);
        reset = 1'b0;
        cyc(1);
        nonce_init = 32'd5; hit = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            check($sformatf("trace_c%0d", c), 32'(exp_trace(c)), 32'({block, load_msg, round_en, round_t, done, busy}));
            if (c < 200) cyc(1);
        end
        check("n5_nonce_check", nonce, 5);
        check("n5_msg_sel_check", msg_sel, 2);
        cyc(1);
        check("n6_nonce_init", nonce, 6);
        check("n6_block_init", block, 0);
        hit = 1'b1;
        cyc(49);
        nonce_init = 32'd99; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("start_busy_ignored", nonce, 6);
        cyc(149);
        check("n6_done", done, 1);
        check("n6_found", found, 1);
        check("n6_nonce", nonce, 6);
        cyc(1);
        check("n6_idle_busy", busy, 0);
        check("n6_idle_done", done, 0);
        check("n6_found_hold", found, 1);
        hit = 1'b0; nonce_init = 32'hFFFFFFFF; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("ex_found_cleared", found, 0);
        cyc(199);
        check("ex_done", done, 1);
        check("ex_exhausted", exhausted, 1);
        check("ex_found", found, 0);
        check("ex_nonce", nonce, 32'hFFFFFFFF);
        cyc(1);
        check("ex_idle_busy", busy, 0);
        check("ex_hold", exhausted, 1);
        check("ex_nowrap", nonce, 32'hFFFFFFFF);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);
        nonce_init = 32'd10; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("st_ex_cleared", exhausted, 0);
        cyc(9);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(189);
        check("st_done", done, 1);
        check("st_found", found, 0);
        check("st_exhausted", exhausted, 0);
        check("st_nonce", nonce, 10);
        cyc(1);
        check("st_idle_busy", busy, 0);
        check("st_nonce_hold", nonce, 10);
        cyc(2);
        check("st_no_restart", {busy, load_msg}, 0);
        nonce_init = 32'd7; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(139);
        check("rs_pre_round", {block, round_en, round_t}, {2'd2, 1'b1, 6'd5});
        reset = 1'b1;
        #1;
        check("rs_busy", busy, 0);
        check("rs_outs", {block, msg_sel, load_msg, round_en, round_t, done, found, exhausted}, 0);
        check("rs_nonce", nonce, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(3);
        check("rs_stays_idle", {busy, done}, 0);
        nonce_init = 32'd3; hit = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(198);
        stop = 1'b1;
        cyc(1);
        check("hs_done", done, 1);
        check("hs_found", found, 1);
        check("hs_nonce", nonce, 3);
        stop = 1'b0;
        cyc(1);
        check("hs_idle", busy, 0);
        check("hs_found_hold", found, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
